// File: rtl/spu32_cpu_exec_seq_pkg.sv
// spu32_cpu_exec_seq_pkg: shared ALU op codes, branch condition codes, execute-stage
// state encoding and the watchdog abort value.
package spu32_cpu_exec_seq_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLT  = 4'd5;
    localparam logic [3:0] ALUOP_SLTU = 4'd6;
    localparam logic [3:0] ALUOP_SLL  = 4'd7;
    localparam logic [3:0] ALUOP_SRL  = 4'd8;
    localparam logic [3:0] ALUOP_SRA  = 4'd9;
    localparam logic [3:0] ALUOP_MUL  = 4'd10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {
        EXEC_IDLE  = 2'd0,
        EXEC_ISSUE = 2'd1,
        EXEC_WAIT  = 2'd2,
        EXEC_DONE  = 2'd3
    } exec_state_t;

    localparam logic [31:0] EXEC_WD_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/spu32_cpu_exec_seq_if.sv
// spu32_cpu_exec_seq_if: op-in handshake, ALU connection and result-out handshake of the
// execute sequencer. slave = sequencer view, master = surrounding pipeline/ALU view.
interface spu32_cpu_exec_seq_if;
    logic        I_valid;
    logic        O_ready;
    logic [3:0]  I_aluop;
    logic [31:0] I_dataS1;
    logic [31:0] I_dataS2;
    logic        I_is_branch;
    logic [2:0]  I_funct3;
    logic        O_alu_en;
    logic [3:0]  O_alu_op;
    logic [31:0] O_alu_s1;
    logic [31:0] O_alu_s2;
    logic        I_alu_busy;
    logic [31:0] I_alu_data;
    logic        I_alu_lt;
    logic        I_alu_ltu;
    logic        I_alu_eq;
    logic        O_valid;
    logic        I_ready;
    logic [31:0] O_data;
    logic        O_branch_taken;
    logic        O_error;

    modport slave (
        input  I_valid, I_aluop, I_dataS1, I_dataS2, I_is_branch, I_funct3,
        input  I_alu_busy, I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq, I_ready,
        output O_ready, O_alu_en, O_alu_op, O_alu_s1, O_alu_s2,
        output O_valid, O_data, O_branch_taken, O_error
    );

    modport master (
        output I_valid, I_aluop, I_dataS1, I_dataS2, I_is_branch, I_funct3,
        output I_alu_busy, I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq, I_ready,
        input  O_ready, O_alu_en, O_alu_op, O_alu_s1, O_alu_s2,
        input  O_valid, O_data, O_branch_taken, O_error
    );
endinterface

// File: rtl/spu32_cpu_branch_eval.sv
// spu32_cpu_branch_eval: combinational branch condition from funct3 and ALU compare flags.
// Ports: I_funct3 condition code, I_lt/I_ltu/I_eq ALU flags, O_cond condition result.
module spu32_cpu_branch_eval
    import spu32_cpu_exec_seq_pkg::*;
(
    input  logic [2:0] I_funct3,
    input  logic       I_lt,
    input  logic       I_ltu,
    input  logic       I_eq,
    output logic       O_cond
);
    always_comb
        O_cond = I_funct3 == BR_EQ  ?  I_eq  :
                 I_funct3 == BR_NE  ? !I_eq  :
                 I_funct3 == BR_LT  ?  I_lt  :
                 I_funct3 == BR_GE  ? !I_lt  :
                 I_funct3 == BR_LTU ?  I_ltu :
                 I_funct3 == BR_GEU ? !I_ltu : 1'b0;
endmodule

// File: rtl/spu32_cpu_exec_seq.sv
// spu32_cpu_exec_seq: execute-stage sequencer between decoder, ALU and writeback
module spu32_cpu_exec_seq
    import spu32_cpu_exec_seq_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 64
)
(
    input  logic                    I_clk,
    input  logic                    I_reset_n,
    spu32_cpu_exec_seq_if.slave     io
);
    exec_state_t state;
    logic        is_branch_q;
    logic [2:0]  funct3_q;
    logic        cond;
    logic        accept;
    logic        abort;

    spu32_cpu_branch_eval u_branch_eval (
        .I_funct3 (funct3_q),
        .I_lt     (io.I_alu_lt),
        .I_ltu    (io.I_alu_ltu),
        .I_eq     (io.I_alu_eq),
        .O_cond   (cond)
    );

    assign io.O_ready = state == EXEC_IDLE || (state == EXEC_DONE && io.I_ready);
    assign accept = io.O_ready && io.I_valid;
    assign io.O_alu_en = state == EXEC_ISSUE || (state == EXEC_WAIT && io.I_alu_busy && !abort);

`ifdef EXEC_WATCHDOG_EN
    logic [7:0] wd_cnt;
    assign abort = state == EXEC_WAIT && io.I_alu_busy && wd_cnt == 8'(WATCHDOG_CYCLES);
    always_ff @(posedge I_clk or negedge I_reset_n)
        if (!I_reset_n) begin
            wd_cnt     <= '0;
            io.O_error <= 1'b0;
        end else begin
            wd_cnt <= state == EXEC_ISSUE ? 8'd0 : state == EXEC_WAIT ? wd_cnt + 8'd1 : wd_cnt;
            if (abort)
                io.O_error <= 1'b1;
            else if (state == EXEC_DONE && io.I_ready)
                io.O_error <= 1'b0;
        end
`else
    assign abort = 1'b0;
    assign io.O_error = 1'b0;
`endif

    always_ff @(posedge I_clk or negedge I_reset_n)
        if (!I_reset_n) begin
            state             <= EXEC_IDLE;
            io.O_valid        <= 1'b0;
            io.O_data         <= '0;
            io.O_branch_taken <= 1'b0;
            io.O_alu_op       <= '0;
            io.O_alu_s1       <= '0;
            io.O_alu_s2       <= '0;
            is_branch_q       <= 1'b0;
            funct3_q          <= '0;
        end else begin
            if (accept) begin
                io.O_alu_op <= io.I_aluop;
                io.O_alu_s1 <= io.I_dataS1;
                io.O_alu_s2 <= io.I_dataS2;
                is_branch_q <= io.I_is_branch;
                funct3_q    <= io.I_funct3;
            end
            case (state)
                EXEC_IDLE:
                    if (io.I_valid)
                        state <= EXEC_ISSUE;
                EXEC_ISSUE:
                    state <= EXEC_WAIT;
                EXEC_WAIT:
                    if (abort) begin
                        io.O_data         <= EXEC_WD_ABORT_DATA;
                        io.O_branch_taken <= 1'b0;
                        io.O_valid        <= 1'b1;
                        state             <= EXEC_DONE;
                    end else if (!io.I_alu_busy) begin
                        io.O_data         <= io.I_alu_data;
                        io.O_branch_taken <= is_branch_q && cond;
                        io.O_valid        <= 1'b1;
                        state             <= EXEC_DONE;
                    end
                EXEC_DONE:
                    if (io.I_ready) begin
                        io.O_valid <= 1'b0;
                        state      <= io.I_valid ? EXEC_ISSUE : EXEC_IDLE;
                    end
            endcase
        end
endmodule

// File: doc/spu32_cpu_exec_seq.md
Name: spu32_cpu_exec_seq

Overview:
Execute-stage sequencer between the decoder and the ALU (spu32_cpu_alu), and between the ALU and writeback/fetch.
- Accepts one decoded ALU/branch operation per valid/ready handshake.
- Drives the ALU enable, holding it across multi-cycle shift and multiply operations.
- Captures the ALU result and evaluates the branch condition from the ALU comparison flags.
- Presents the result to writeback through a second valid/ready handshake.

Parameters:
WATCHDOG_CYCLES, 64, maximum WAIT-state cycles before abort (used only with EXEC_WATCHDOG_EN)

Ports:
I_clk  in  1  clock; all state updates on rising edge
I_reset_n  in  1  asynchronous, active-low reset
I_valid  in  1  upstream op valid
O_ready  out  1  sequencer can accept an op this cycle
I_aluop  in  4  ALUOP_* code
I_dataS1  in  32  operand 1
I_dataS2  in  32  operand 2
I_is_branch  in  1  op is a conditional branch
I_funct3  in  3  branch condition code
O_alu_en  out  1  to ALU I_en
O_alu_op  out  4  to ALU I_aluop (registered copy)
O_alu_s1  out  32  to ALU I_dataS1 (registered)
O_alu_s2  out  32  to ALU I_dataS2 (registered)
I_alu_busy  in  1  from ALU O_busy
I_alu_data  in  32  from ALU O_data
I_alu_lt  in  1  from ALU O_lt
I_alu_ltu  in  1  from ALU O_ltu
I_alu_eq  in  1  from ALU O_eq
O_valid  out  1  result valid to downstream
I_ready  in  1  downstream accepts result
O_data  out  32  captured ALU result
O_branch_taken  out  1  branch decision; 0 for non-branch ops
O_error  out  1  watchdog abort flag (tied 0 without EXEC_WATCHDOG_EN)

Behaviour:
- Reset (async, I_reset_n=0):
  - state=IDLE.
  - O_valid, O_alu_en, O_branch_taken, O_error = 0.
  - O_data, O_alu_s1, O_alu_s2 = 0; O_alu_op = 0.
  - Reset mid-operation abandons the op; no output handshake occurs.
- States IDLE, ISSUE, WAIT, DONE (encoding from the package).
- O_ready = (state==IDLE) || (state==DONE && I_ready).
- IDLE:
  - On I_valid, register aluop, S1, S2, is_branch, funct3, then go to ISSUE.
- ISSUE:
  - O_alu_en=1 for exactly this cycle; next state WAIT.
- WAIT:
  - I_alu_busy is first sampled in the cycle after ISSUE.
  - O_alu_en = I_alu_busy; enable is held while the ALU is busy so shift/mul progress.
  - When I_alu_busy=0: O_data<=I_alu_data, O_branch_taken<=is_branch && cond, O_valid<=1, go to DONE.
- DONE:
  - O_valid=1; outputs stable until accepted.
  - On I_ready && I_valid: capture the new op and go to ISSUE (back-to-back).
  - On I_ready only: go to IDLE and clear O_valid.
- cond by funct3 (flags are valid for any aluop; decoder issues branches as ALUOP_SUB):
  - 000 eq; 001 !eq
  - 100 lt; 101 !lt
  - 110 ltu; 111 !ltu
  - 010/011 → 0
- Latency from IDLE acceptance to O_valid:
  - single-cycle op: 3 cycles
  - shift by n: 3+n+1 cycles
- Operands are held constant at the ALU outputs from ISSUE through DONE.
- No combinational path from I_valid to O_alu_*. O_ready depends combinationally on I_ready only in DONE.

Optional Feature:
EXEC_WATCHDOG_EN:
- Defined:
  - 8-bit counter cleared in ISSUE, incremented each WAIT cycle.
  - When the count reaches WATCHDOG_CYCLES with busy still high: O_alu_en=0, O_data=32'hDEADBEEF, O_branch_taken=0, O_error=1, go to DONE.
  - O_error clears on handshake.
- Undefined: no counter; O_error tied 0; WAIT is unbounded.

Decomposition:
- Shared package/header (alongside aludefs):
  - ALUOP_* codes
  - branch funct3 constants BR_EQ/BR_NE/BR_LT/BR_GE/BR_LTU/BR_GEU
  - state encoding EXEC_IDLE/ISSUE/WAIT/DONE
  - watchdog abort value
- Sub-module spu32_cpu_branch_eval: purely combinational mapping (funct3, lt, ltu, eq) → cond, instantiated once.

Test Plan:
- ADD 5+7, I_ready=1 held → O_valid 3 cycles after acceptance, O_data=12, O_branch_taken=0, O_alu_en high exactly 1 cycle.
- BLT (SUB, funct3=100) S1=0xFFFFFFFF, S2=1 → taken=1; same operands with BLTU (110) → taken=0; BEQ 4,4 → taken=1.
- SLL 1 by 5 → O_alu_en held through busy, O_data=32, O_valid at cycle 9; operands stable throughout.
- Backpressure: I_ready=0 for 4 cycles in DONE → O_data/O_valid stable, O_ready=0; then I_ready=1 with I_valid=1 → next op enters ISSUE the following cycle.
- Deassert I_reset_n during WAIT of a shift → all outputs 0 immediately, state IDLE, no O_valid pulse.
- With EXEC_WATCHDOG_EN, WATCHDOG_CYCLES=4, I_alu_busy forced 1 → O_valid with O_data=0xDEADBEEF, O_error=1; O_error cleared after handshake.
